// File: rtl/queen_pkg.sv
// Shared types and constants for the 8-queens solution streamer.
package queen_pkg;

  localparam int unsigned N_ROWS = 8;
  localparam int unsigned ROW_W  = 8;

  typedef enum logic [0:0] {
    StIdle,
    StStream
  } state_e;

endpackage

// File: rtl/onehot_col_enc.sv
// Converts one board row byte into a queen column index plus a not-one-hot flag.
module onehot_col_enc
  import queen_pkg::*;
(
  input  logic [ROW_W-1:0] row_i,
  output logic [2:0]       col_o,
  output logic             err_o
);

  // Ascending scan, so the highest set bit wins; bit 7 maps to column 0.
  always_comb begin
    col_o = 3'd0;
    for (int i = 0; i < ROW_W; i++) begin
      if (row_i[i]) col_o = 3'(ROW_W - 1 - i);
    end
  end

  assign err_o = (row_i == '0) | ((row_i & (row_i - 8'd1)) != '0);

endmodule

// File: rtl/solution_streamer.sv
// Snapshots a completed 8-queens board on the solver READY rising edge and
// streams it downstream as eight row/column beats with valid/ready handshake.
module solution_streamer
  import queen_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    solver_ready,
  input  logic [N_ROWS*ROW_W-1:0] board_in,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [2:0]              m_row,
  output logic [2:0]              m_col,
  output logic                    m_err,
  output logic                    m_last,
  output logic                    busy,
  output logic [CNT_W-1:0]        sol_count,
  output logic [CNT_W-1:0]        drop_count
);

  state_e                    state_q, state_d;
  logic                      rdy_q, rdy_d;
  logic [N_ROWS*ROW_W-1:0]   snap_q, snap_d;
  logic [2:0]                row_q, row_d;
  logic [CNT_W-1:0]          sol_q, sol_d;
  logic [CNT_W-1:0]          drop_q, drop_d;

  logic             capture;
  logic             accept;
  logic             last_row;
  logic [ROW_W-1:0] row_byte;
  logic [2:0]       enc_col;
  logic             enc_err;

  assign capture  = solver_ready & ~rdy_q;
  assign m_valid  = (state_q == StStream);
  assign accept   = m_valid & m_ready;
  assign last_row = (row_q == 3'(N_ROWS - 1));
  assign row_byte = snap_q[{row_q, 3'b000} +: ROW_W];

  onehot_col_enc u_enc (
    .row_i (row_byte),
    .col_o (enc_col),
    .err_o (enc_err)
  );

  always_comb begin
    state_d = state_q;
    rdy_d   = solver_ready;
    snap_d  = snap_q;
    row_d   = row_q;
    sol_d   = sol_q;
    drop_d  = drop_q;
    unique case (state_q)
      StIdle: begin
        if (capture) begin
          state_d = StStream;
          snap_d  = board_in;
          row_d   = '0;
        end
      end
      StStream: begin
        if (accept && last_row) begin
          sol_d = sol_q + CNT_W'(1);
          row_d = '0;
          // A fresh board arriving on the final accept is taken, not dropped.
          if (capture) snap_d = board_in;
          else         state_d = StIdle;
        end else begin
          if (accept) row_d = row_q + 3'd1;
          if (capture && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rdy_q   <= 1'b1;
      snap_q  <= '0;
      row_q   <= '0;
      sol_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      snap_q  <= snap_d;
      row_q   <= row_d;
      sol_q   <= sol_d;
      drop_q  <= drop_d;
    end
  end

  assign m_row      = row_q;
  assign m_col      = m_valid ? enc_col : 3'd0;
  assign m_err      = m_valid & enc_err;
  assign m_last     = m_valid & last_row;
  assign busy       = m_valid;
  assign sol_count  = sol_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_solution_streamer.sv
// Directed plus randomized checks of solution_streamer against a row-level board model.
module tb_solution_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        solver_ready;
  logic [63:0] board_in;
  logic        m_valid;
  logic        m_ready;
  logic [2:0]  m_row;
  logic [2:0]  m_col;
  logic        m_err;
  logic        m_last;
  logic        busy;
  logic [7:0]  sol_count;
  logic [7:0]  drop_count;

  int checks   = 0;
  int failures = 0;
  int exp_sol  = 0;
  int exp_drop = 0;

  solution_streamer #(.CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .solver_ready (solver_ready),
    .board_in     (board_in),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_row        (m_row),
    .m_col        (m_col),
    .m_err        (m_err),
    .m_last       (m_last),
    .busy         (busy),
    .sol_count    (sol_count),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queen column: 7 minus the highest set bit position; empty row reads as column 0.
  function automatic logic [2:0] ref_col(input logic [7:0] b);
    int hi = -1;
    for (int j = 0; j < 8; j++) if (b[j]) hi = j;
    return (hi < 0) ? 3'd0 : 3'(7 - hi);
  endfunction

  function automatic logic ref_err(input logic [7:0] b);
    return $countones(b) != 1;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, m_valid, 0);
    chk({tag, ".row"},   m_row,   0);
    chk({tag, ".col"},   m_col,   0);
    chk({tag, ".err"},   m_err,   0);
    chk({tag, ".last"},  m_last,  0);
    chk({tag, ".busy"},  busy,    0);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, ".sol"},  sol_count,  exp_sol[7:0]);
    chk({tag, ".drop"}, drop_count, exp_drop[7:0]);
  endtask

  task automatic chk_beat(input string tag, input logic [63:0] b, input int beat);
    logic [7:0] rb;
    rb = b[8*beat +: 8];
    chk({tag, ".valid"}, m_valid, 1);
    chk({tag, ".busy"},  busy,    1);
    chk({tag, ".row"},   m_row,   beat);
    chk({tag, ".col"},   m_col,   ref_col(rb));
    chk({tag, ".err"},   m_err,   ref_err(rb));
    chk({tag, ".last"},  m_last,  beat == 7);
  endtask

  // Produce a READY rising edge with board b; the beat for row 0 must follow at once.
  task automatic capture(input logic [63:0] b);
    solver_ready = 1'b0;
    tick();
    board_in     = b;
    solver_ready = 1'b1;
    tick();
  endtask

  // mode 0: always ready, 1: toggle starting low, 2: random. Walks beats first..last.
  task automatic drain(input string tag, input logic [63:0] b, input int mode,
                       input int first, input int last, output int cycles);
    int beat  = first;
    int guard = 0;
    cycles = 0;
    while (beat <= last && guard < 200) begin
      chk_beat(tag, b, beat);
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = cycles[0];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      cycles++;
      guard++;
      tick();
      if (m_ready) beat++;
    end
    if (guard >= 200) chk({tag, ".timeout"}, 1, 0);
    m_ready = 1'b0;
    if (beat > 7) exp_sol++;
  endtask

  function automatic logic [63:0] rand_board(input bit onehot);
    logic [63:0] b;
    int perm[8];
    for (int i = 0; i < 8; i++) perm[i] = i;
    for (int i = 7; i > 0; i--) begin
      int j = int'($urandom_range(0, i));
      int t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int i = 0; i < 8; i++) begin
      if (onehot) b[8*i +: 8] = 8'h80 >> perm[i];
      else        b[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
    end
    return b;
  endfunction

  initial begin
    logic [63:0] board_a;
    logic [63:0] board_b;
    logic [63:0] board_c;
    int          cyc;

    board_a = 64'h04_40_10_02_20_01_08_80;
    board_c = 64'h04_40_11_02_00_01_08_80;
    rst          = 1'b1;
    solver_ready = 1'b1;
    m_ready      = 1'b0;
    board_in     = '0;

    repeat (2) tick();
    chk_idle("reset");
    chk_counts("reset");
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("post_reset.valid", m_valid, 0);
    end
    chk_counts("post_reset");

    capture(board_a);
    drain("board_a", board_a, 0, 0, 7, cyc);
    chk("board_a.cycles", cyc, 8);
    chk_idle("after_a");
    chk_counts("after_a");

    capture(board_a);
    drain("stall", board_a, 1, 0, 7, cyc);
    chk("stall.cycles", cyc, 16);
    chk_idle("after_stall");
    chk_counts("after_stall");

    capture(board_c);
    drain("err_board", board_c, 0, 0, 7, cyc);
    chk_counts("after_err");

    // Drop while stalled on row 2, then a new capture exactly on the row-7 accept.
    board_b = rand_board(1);
    capture(board_a);
    drain("drop_a01", board_a, 0, 0, 1, cyc);
    solver_ready = 1'b0;
    tick();
    board_in     = board_b;
    solver_ready = 1'b1;
    tick();
    exp_drop++;
    chk_beat("drop_hold", board_a, 2);
    chk_counts("drop");
    solver_ready = 1'b0;
    drain("drop_a26", board_a, 0, 2, 6, cyc);
    chk_beat("a_row7", board_a, 7);
    m_ready      = 1'b1;
    solver_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    exp_sol++;
    chk_beat("back_to_back", board_b, 0);
    chk_counts("back_to_back");
    drain("board_b", board_b, 2, 0, 7, cyc);
    chk_idle("after_b");

    // Saturate the drop counter without disturbing the held board.
    capture(board_a);
    for (int i = 0; i < 260; i++) begin
      solver_ready = 1'b0;
      tick();
      board_in     = ~board_a;
      solver_ready = 1'b1;
      tick();
      if (exp_drop < 255) exp_drop++;
    end
    chk_counts("drop_sat");
    drain("sat_a", board_a, 0, 0, 7, cyc);
    chk_counts("after_sat");

    for (int n = 0; n < 8; n++) begin
      board_b = rand_board(n[0]);
      capture(board_b);
      drain("random", board_b, 2, 0, 7, cyc);
      chk_idle("random_idle");
      chk_counts("random");
    end

    // Asynchronous reset mid-board aborts immediately and clears the counters.
    capture(board_a);
    drain("pre_rst", board_a, 0, 0, 3, cyc);
    chk_beat("pre_rst_row4", board_a, 4);
    rst = 1'b1;
    #2;
    chk("rst_async.valid", m_valid, 0);
    rst = 1'b0;
    exp_sol  = 0;
    exp_drop = 0;
    tick();
    chk_idle("after_rst");
    chk_counts("after_rst");
    repeat (3) tick();
    chk("after_rst_quiet.valid", m_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
